// File: rtl/quantum_ecc_encoder.sv
// Pair-repetition encoder: each logical qubit b becomes the pair {b,b}, built
// serially one qubit per cycle, then presented with an error-injection mask.
module quantum_ecc_encoder #(
  parameter int MAX_QUBITS = 8,
  parameter int STATE_W    = 2 * MAX_QUBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_QUBITS-1:0] logical_bits,
  input  logic [3:0]            qubit_count,
  input  logic [STATE_W-1:0]    inject_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STATE_W-1:0]    encoded_state,
  output logic [3:0]            encoded_qubits,
  output logic                  error,
  output logic [31:0]           encode_count,
  output logic [31:0]           reject_count
);

  localparam int IDX_W = $clog2(MAX_QUBITS);

  typedef enum logic [1:0] {IDLE, ENCODE, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MAX_QUBITS-1:0] bits_q, bits_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [STATE_W-1:0]    mask_q, mask_d;
  logic [STATE_W-1:0]    work_q, work_d;
  logic [STATE_W-1:0]    enc_state_q, enc_state_d;
  logic [3:0]            enc_qubits_q, enc_qubits_d;
  logic                  out_valid_q, out_valid_d;
  logic                  error_q, error_d;
  logic [31:0]           encode_count_q, encode_count_d;
  logic [31:0]           reject_count_q, reject_count_d;

  logic                  accept, bad_count, req_ok, req_bad, last, hs;
  logic [3:0]            idx_ext;
  logic [STATE_W-1:0]    work_next;

  assign accept    = in_valid && (state_q == IDLE);
  assign bad_count = (qubit_count == 4'd0) || (qubit_count > 4'(MAX_QUBITS));
  assign req_ok    = accept && !bad_count;
  assign req_bad   = accept && bad_count;
  assign idx_ext   = 4'(idx_q);
  assign last      = (state_q == ENCODE) && (idx_ext == (cnt_q - 4'd1));
  assign hs        = out_valid_q && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_ok) state_d = ENCODE;
      ENCODE:  if (last)   state_d = OUTPUT;
      OUTPUT:  if (hs)     state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath and counter next values
  always_comb begin
    work_next = work_q;
    work_next[{idx_q, 1'b0} +: 2] = {2{bits_q[idx_q]}};

    idx_d          = idx_q;
    bits_d         = bits_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    work_d         = work_q;
    enc_state_d    = enc_state_q;
    enc_qubits_d   = enc_qubits_q;
    out_valid_d    = out_valid_q;
    encode_count_d = encode_count_q;
    reject_count_d = reject_count_q;
    error_d        = req_bad;

    if (req_bad) reject_count_d = reject_count_q + 32'd1;

    if (req_ok) begin
      bits_d = logical_bits;
      cnt_d  = qubit_count;
      mask_d = inject_mask;
      work_d = '0;
      idx_d  = '0;
    end

    if (state_q == ENCODE) begin
      work_d = work_next;
      idx_d  = idx_q + 1'b1;
      // Pairs above the count were cleared on accept, so the mask alone lands there.
      if (last) begin
        enc_state_d  = work_next ^ mask_q;
        enc_qubits_d = cnt_q;
        out_valid_d  = 1'b1;
      end
    end

    if (hs) begin
      out_valid_d    = 1'b0;
      encode_count_d = encode_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= '0;
      bits_q         <= '0;
      cnt_q          <= '0;
      mask_q         <= '0;
      work_q         <= '0;
      enc_state_q    <= '0;
      enc_qubits_q   <= '0;
      out_valid_q    <= 1'b0;
      error_q        <= 1'b0;
      encode_count_q <= '0;
      reject_count_q <= '0;
    end else begin
      idx_q          <= idx_d;
      bits_q         <= bits_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      work_q         <= work_d;
      enc_state_q    <= enc_state_d;
      enc_qubits_q   <= enc_qubits_d;
      out_valid_q    <= out_valid_d;
      error_q        <= error_d;
      encode_count_q <= encode_count_d;
      reject_count_q <= reject_count_d;
    end
  end

  // Output logic
  always_comb begin
    in_ready       = (state_q == IDLE);
    out_valid      = out_valid_q;
    encoded_state  = enc_state_q;
    encoded_qubits = enc_qubits_q;
    error          = error_q;
    encode_count   = encode_count_q;
    reject_count   = reject_count_q;
  end

endmodule

// File: tb/tb_quantum_ecc_encoder.sv
// Bench for quantum_ecc_encoder: vector table plus hand-written sequences, with
// a scoreboard of expected outputs popped at each output handshake.
module tb_quantum_ecc_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  logical_bits = '0;
  logic [3:0]  qubit_count = '0;
  logic [15:0] inject_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] encoded_state;
  logic [3:0]  encoded_qubits;
  logic        error;
  logic [31:0] encode_count;
  logic [31:0] reject_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] st;
    logic [3:0]  q;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  bits;
    logic [3:0]  cnt;
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[7];

  quantum_ecc_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .logical_bits(logical_bits), .qubit_count(qubit_count),
    .inject_mask(inject_mask), .out_valid(out_valid), .out_ready(out_ready),
    .encoded_state(encoded_state), .encoded_qubits(encoded_qubits),
    .error(error), .encode_count(encode_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Handshake happens at the next posedge; compare against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'(encoded_state), 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_encoded_state", 32'(encoded_state), 32'(e.st));
        check("sb_encoded_qubits", 32'(encoded_qubits), 32'(e.q));
      end
    end
  end

  task automatic wait_out(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic run_txn(input string name, input logic [7:0] bits, input logic [3:0] cnt,
                         input logic [15:0] mask, input logic [15:0] exp_st);
    logic [31:0] ec0;
    ec0 = encode_count;
    out_ready    = 1'b1;
    logical_bits = bits;
    qubit_count  = cnt;
    inject_mask  = mask;
    in_valid     = 1'b1;
    sb.push_back('{st: exp_st, q: cnt});
    tick;
    in_valid = 1'b0;
    check({name, "_busy"}, 32'(in_ready), 32'd0);
    wait_out(name, int'(cnt));
    tick;
    check({name, "_encode_count"}, encode_count, ec0 + 32'd1);
    check({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ec0, rc0;
    logic [15:0] last_st;

    vecs[0] = '{bits: 8'h0B, cnt: 4'd4, mask: 16'h0000, exp: 16'h00CF};
    vecs[1] = '{bits: 8'hFF, cnt: 4'd8, mask: 16'h0001, exp: 16'hFFFE};
    vecs[2] = '{bits: 8'hFF, cnt: 4'd8, mask: 16'h0000, exp: 16'hFFFF};
    vecs[3] = '{bits: 8'h01, cnt: 4'd1, mask: 16'h0000, exp: 16'h0003};
    vecs[4] = '{bits: 8'hFA, cnt: 4'd3, mask: 16'h0000, exp: 16'h000C};
    vecs[5] = '{bits: 8'h15, cnt: 4'd5, mask: 16'hF000, exp: 16'hF333};
    vecs[6] = '{bits: 8'hA5, cnt: 4'd8, mask: 16'h0000, exp: 16'hCC33};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_encoded_state", 32'(encoded_state), 32'd0);
    check("rst_encoded_qubits", 32'(encoded_qubits), 32'd0);
    check("rst_encode_count", encode_count, 32'd0);
    check("rst_reject_count", reject_count, 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].bits, vecs[i].cnt, vecs[i].mask, vecs[i].exp);
      check($sformatf("vec%0d_total", i), encode_count, 32'(i + 1));
    end

    // Rejected requests: count 0 and count 9
    last_st = encoded_state;
    ec0 = encode_count;
    for (int k = 0; k < 2; k++) begin
      qubit_count  = (k == 0) ? 4'd0 : 4'd9;
      logical_bits = 8'hFF;
      in_valid     = 1'b1;
      tick;
      in_valid = 1'b0;
      check($sformatf("rej%0d_error_high", k), 32'(error), 32'd1);
      check($sformatf("rej%0d_in_ready", k), 32'(in_ready), 32'd1);
      check($sformatf("rej%0d_reject_count", k), reject_count, 32'(k + 1));
      tick;
      check($sformatf("rej%0d_error_low", k), 32'(error), 32'd0);
      check($sformatf("rej%0d_out_valid", k), 32'(out_valid), 32'd0);
    end
    check("rej_encode_count", encode_count, ec0);
    check("rej_state_kept", 32'(encoded_state), 32'(last_st));

    // Backpressure with in_valid pulsed while busy
    ec0 = encode_count;
    rc0 = reject_count;
    out_ready    = 1'b0;
    logical_bits = 8'hFC;
    qubit_count  = 4'd2;
    inject_mask  = 16'h0000;
    in_valid     = 1'b1;
    sb.push_back('{st: 16'h0000, q: 4'd2});
    tick;
    in_valid = 1'b0;
    wait_out("bp", 2);
    for (int i = 0; i < 10; i++) begin
      in_valid    = (i == 3);
      qubit_count = 4'd0;
      tick;
      check($sformatf("bp_hold%0d_state", i), 32'(encoded_state), 32'h0);
      check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_ready", i), 32'(in_ready), 32'd0);
    end
    check("bp_no_reject", reject_count, rc0);
    check("bp_no_encode", encode_count, ec0);
    out_ready = 1'b1;
    tick;
    check("bp_encode_count", encode_count, ec0 + 32'd1);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);

    // Reset in the middle of an encode
    logical_bits = 8'hFF;
    qubit_count  = 4'd8;
    inject_mask  = 16'h0000;
    in_valid     = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_state", 32'(encoded_state), 32'd0);
    check("mid_rst_qubits", 32'(encoded_qubits), 32'd0);
    check("mid_rst_encode_count", encode_count, 32'd0);
    check("mid_rst_reject_count", reject_count, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("post_rst_no_output", 32'(out_valid), 32'd0);
    run_txn("post_rst", 8'h01, 4'd1, 16'h0000, 16'h0003);

    // Back-to-back requests, out_ready held high
    ec0 = encode_count;
    out_ready    = 1'b1;
    logical_bits = 8'h01;
    qubit_count  = 4'd2;
    inject_mask  = 16'h0000;
    in_valid     = 1'b1;
    sb.push_back('{st: 16'h0003, q: 4'd2});
    tick;
    check("b2b_first_accept", 32'(in_ready), 32'd0);
    logical_bits = 8'h02;
    inject_mask  = 16'h0100;
    sb.push_back('{st: 16'h010C, q: 4'd2});
    wait_out("b2b_first", 2);
    tick;
    check("b2b_ready_after_hs", 32'(in_ready), 32'd1);
    tick;
    check("b2b_second_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_out("b2b_second", 2);
    tick;
    check("b2b_encode_count", encode_count, ec0 + 32'd2);

    tick;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
